// File: rtl/pipelined_data_memory.sv
// pipelined_data_memory: parametrised single-port data memory with byte enables, read pipeline and post-reset zero-fill
module pipelined_data_memory #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 10,
  parameter int READ_LAT = 1,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [DATA_W/8-1:0] req_be,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                init_done
);
  localparam int LANES = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;
  typedef enum logic {INIT, RUN} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] dat [READ_LAT];
  logic [READ_LAT-1:0] vld;
  logic acc;
  if (DATA_W % 8 != 0 || READ_LAT < 1 || READ_LAT > 4) begin : g_bad_cfg
    $error("pipelined_data_memory: illegal DATA_W or READ_LAT");
  end
  assign req_ready = state == RUN;
  assign init_done = state == RUN;
  assign acc = rst_n && req_valid && req_ready;
  assign rsp_valid = vld[READ_LAT-1];
  assign rsp_rdata = rsp_valid ? dat[READ_LAT-1] : '0;
  always_comb state_nx = (state == RUN || !INIT_CLEAR || &ptr) ? RUN : INIT;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= INIT;
      ptr <= '0;
      vld <= '0;
    end else begin
      state <= state_nx;
      if (state == INIT) ptr <= ptr + 1'b1;
      vld[0] <= acc && !req_we;
      for (int i = 1; i < READ_LAT; i++) vld[i] <= vld[i-1];
    end
  end
  always_ff @(posedge clk) begin
    if (rst_n && state == INIT && INIT_CLEAR) mem[ptr] <= '0;
    else if (acc && req_we)
      for (int i = 0; i < LANES; i++)
        if (req_be[i]) mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
    dat[0] <= mem[req_addr];
    for (int i = 1; i < READ_LAT; i++) dat[i] <= dat[i-1];
  end
endmodule

// File: tb/tb_pipelined_data_memory.sv
// tb_pipelined_data_memory: directed self-checking bench for pipelined_data_memory
module tb_pipelined_data_memory;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0;
  logic req_we = 1'b0;
  logic [2:0] req_be = '0;
  logic [5:0] req_addr = '0;
  logic [23:0] req_wdata = '0;
  logic rdy1, rdy2, rdy4, rdyn;
  logic rv1, rv2, rv4, rvn;
  logic [23:0] rd1, rd2, rd4, rdn;
  logic dn1, dn2, dn4, dnn;
  logic rv_a [3];
  logic [23:0] rd_a [3];
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  pipelined_data_memory #(.DATA_W(24), .ADDR_W(6), .READ_LAT(1), .INIT_CLEAR(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy1), .req_we(req_we), .req_be(req_be),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv1), .rsp_rdata(rd1), .init_done(dn1));
  pipelined_data_memory #(.DATA_W(24), .ADDR_W(6), .READ_LAT(2), .INIT_CLEAR(1'b1)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy2), .req_we(req_we), .req_be(req_be),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv2), .rsp_rdata(rd2), .init_done(dn2));
  pipelined_data_memory #(.DATA_W(24), .ADDR_W(6), .READ_LAT(4), .INIT_CLEAR(1'b1)) dut4 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy4), .req_we(req_we), .req_be(req_be),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv4), .rsp_rdata(rd4), .init_done(dn4));
  pipelined_data_memory #(.DATA_W(24), .ADDR_W(6), .READ_LAT(2), .INIT_CLEAR(1'b0)) dutn (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdyn), .req_we(req_we), .req_be(req_be),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rvn), .rsp_rdata(rdn), .init_done(dnn));
  assign rv_a[0] = rv1;
  assign rv_a[1] = rv2;
  assign rv_a[2] = rv4;
  assign rd_a[0] = rd1;
  assign rd_a[1] = rd2;
  assign rd_a[2] = rd4;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [5:0] a, input logic [23:0] d, input logic [2:0] be);
    req_valid = 1'b1;
    req_we = 1'b1;
    req_addr = a;
    req_wdata = d;
    req_be = be;
    step();
  endtask
  task automatic rd(input logic [5:0] a);
    req_valid = 1'b1;
    req_we = 1'b0;
    req_addr = a;
    req_be = '0;
    step();
  endtask
  task automatic test_reset();
    bit early;
    rst_n = 1'b0;
    req_valid = 1'b1;
    req_we = 1'b0;
    req_addr = 6'd5;
    step();
    step();
    checks++;
    if ({rdy2, dn2, rv2, rd2, rdyn} !== 28'd0) begin
      failures++;
      $display("FAIL reset_state: got rdy=%b done=%b rv=%b rd=%h rdyn=%b want all 0", rdy2, dn2, rv2, rd2, rdyn);
    end
    rst_n = 1'b1;
    early = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      step();
      if (k < 64 && (rdy2 !== 1'b0 || rv2 !== 1'b0 || dn2 !== 1'b0)) early = 1'b1;
    end
    checks++;
    if (early !== 1'b0) begin
      failures++;
      $display("FAIL init_quiet: got ready/response during sweep, want none for 63 cycles");
    end
    checks++;
    if (rdy2 !== 1'b1 || dn2 !== 1'b1) begin
      failures++;
      $display("FAIL init_ready: got ready=%b done=%b want 1 1 after 64 cycles", rdy2, dn2);
    end
    step();
    req_valid = 1'b0;
    checks++;
    if (rv2 !== 1'b0) begin
      failures++;
      $display("FAIL init_read_early: got rv=%b want 0", rv2);
    end
    step();
    checks++;
    if (rv2 !== 1'b1 || rd2 !== 24'h000000) begin
      failures++;
      $display("FAIL init_read: got rv=%b rd=%h want 1 000000", rv2, rd2);
    end
  endtask
  task automatic test_write_read();
    wr(6'h12, 24'hABCDEF, 3'b111);
    rd(6'h12);
    req_valid = 1'b0;
    checks++;
    if (rv2 !== 1'b0 || rd2 !== 24'h0) begin
      failures++;
      $display("FAIL wr_rd_early: got rv=%b rd=%h want 0 000000", rv2, rd2);
    end
    step();
    checks++;
    if (rv2 !== 1'b1 || rd2 !== 24'hABCDEF) begin
      failures++;
      $display("FAIL wr_rd_data: got rv=%b rd=%h want 1 abcdef", rv2, rd2);
    end
    step();
    checks++;
    if (rv2 !== 1'b0 || rd2 !== 24'h0) begin
      failures++;
      $display("FAIL wr_rd_after: got rv=%b rd=%h want 0 000000", rv2, rd2);
    end
  endtask
  task automatic test_byte_enable();
    wr(6'h12, 24'h112233, 3'b010);
    rd(6'h12);
    req_valid = 1'b0;
    step();
    checks++;
    if (rv2 !== 1'b1 || rd2 !== 24'hAB22EF) begin
      failures++;
      $display("FAIL be_lane1: got rv=%b rd=%h want 1 ab22ef", rv2, rd2);
    end
    wr(6'h12, 24'hFFFFFF, 3'b000);
    rd(6'h12);
    req_valid = 1'b0;
    step();
    checks++;
    if (rv2 !== 1'b1 || rd2 !== 24'hAB22EF) begin
      failures++;
      $display("FAIL be_none: got rv=%b rd=%h want 1 ab22ef", rv2, rd2);
    end
  endtask
  task automatic test_back_to_back();
    int lats [3] = '{1, 2, 4};
    wr(6'd1, 24'h000001, 3'b111);
    wr(6'd2, 24'h000002, 3'b111);
    wr(6'd3, 24'h000003, 3'b111);
    for (int c = 0; c < 8; c++) begin
      if (c < 3) begin
        req_valid = 1'b1;
        req_we = 1'b0;
        req_addr = 6'(c + 1);
      end else req_valid = 1'b0;
      step();
      for (int j = 0; j < 3; j++) begin
        int k;
        logic ev;
        logic [23:0] ed;
        k = c - (lats[j] - 1);
        ev = k >= 0 && k < 3;
        ed = ev ? 24'(k + 1) : 24'h0;
        checks++;
        if (rv_a[j] !== ev || rd_a[j] !== ed) begin
          failures++;
          $display("FAIL b2b_lat%0d_cyc%0d: got rv=%b rd=%h want %b %h", lats[j], c, rv_a[j], rd_a[j], ev, ed);
        end
      end
    end
  endtask
  task automatic test_reset_inflight();
    bit seen;
    int n;
    rd(6'h12);
    req_valid = 1'b0;
    rst_n = 1'b0;
    step();
    checks++;
    if (rv2 !== 1'b0 || rv4 !== 1'b0) begin
      failures++;
      $display("FAIL inflight_reset: got rv2=%b rv4=%b want 0 0", rv2, rv4);
    end
    step();
    rst_n = 1'b1;
    seen = 1'b0;
    n = 0;
    while (rdy2 !== 1'b1 && n < 100) begin
      step();
      n++;
      if (rv2 !== 1'b0 || rv4 !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || rdy2 !== 1'b1) begin
      failures++;
      $display("FAIL inflight_discard: got stray=%b ready=%b want 0 1", seen, rdy2);
    end
    rd(6'h12);
    req_valid = 1'b0;
    step();
    checks++;
    if (rv2 !== 1'b1 || rd2 !== 24'h0) begin
      failures++;
      $display("FAIL inflight_reinit: got rv=%b rd=%h want 1 000000", rv2, rd2);
    end
  endtask
  task automatic test_init_clear();
    int n;
    wr(6'd7, 24'h00BEEF, 3'b111);
    req_valid = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    req_valid = 1'b1;
    req_we = 1'b0;
    req_addr = 6'd7;
    step();
    checks++;
    if (rdyn !== 1'b1 || rdy2 !== 1'b0) begin
      failures++;
      $display("FAIL noclear_ready: got rdyn=%b rdy2=%b want 1 0", rdyn, rdy2);
    end
    step();
    step();
    checks++;
    if (rvn !== 1'b1 || rdn !== 24'h00BEEF) begin
      failures++;
      $display("FAIL noclear_data: got rv=%b rd=%h want 1 00beef", rvn, rdn);
    end
    n = 0;
    while (rdy2 !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    step();
    req_valid = 1'b0;
    step();
    checks++;
    if (rv2 !== 1'b1 || rd2 !== 24'h0) begin
      failures++;
      $display("FAIL clear_data: got rv=%b rd=%h want 1 000000", rv2, rd2);
    end
  endtask
  initial begin
    test_reset();
    test_write_read();
    test_byte_enable();
    test_back_to_back();
    test_reset_inflight();
    test_init_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
